// File: rtl/fabric_cfg_chain.sv
// Configuration scan chain with shadowed active configuration for routing-mux selectors.
// Latency: a shifted bit reaches ccff_tail after L shifts; an accepted commit updates mem_out on the same edge.
// Backpressure: none; a commit outside FULL, or one failing parity, is rejected and flagged in cmt_err.
// Optional feature: define PARITY_CHECK_EN to append a trailing even-parity bit to the chain.
module fabric_cfg_chain #(
  parameter int NUM_MUX  = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                        prog_clk,
  input  logic                        pReset,
  input  logic                        ccff_head,
  input  logic                        shift_en,
  input  logic                        commit,
  output logic                        ccff_tail,
  output logic [NUM_MUX*SEL_BITS-1:0] mem_out,
  output logic [NUM_MUX*SEL_BITS-1:0] mem_outb,
  output logic                        cfg_valid,
  output logic                        cmt_err,
  output logic                        par_err
);

  localparam int TOTAL = NUM_MUX * SEL_BITS;
`ifdef PARITY_CHECK_EN
  localparam int L = TOTAL + 1;
`else
  localparam int L = TOTAL;
`endif
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} state_t;

  logic [L-1:0]  shreg;
  logic [CW-1:0] cnt;
  state_t        state;
  logic          parity_ok;
  logic          do_load;
  logic          do_reject;
  logic          do_shift;

  // Decode the load state from the bit count and resolve this cycle's action.
  always_comb begin
    state     = EMPTY;
    if (cnt == CNT_FULL) begin
      state = FULL;
    end else if (cnt != '0) begin
      state = LOADING;
    end
`ifdef PARITY_CHECK_EN
    parity_ok = ~^shreg;
`else
    parity_ok = 1'b1;
`endif
    // Commit wins over shift: a shift requested alongside a commit is dropped.
    do_load   = commit && (state == FULL) && parity_ok;
    do_reject = commit && !do_load;
    do_shift  = shift_en && !commit;
  end

  // Serial shift register and saturating bit counter; an accepted commit restarts the count.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (do_shift) begin
        shreg <= {shreg[L-2:0], ccff_head};
      end
      if (do_load) begin
        cnt <= '0;
      end else if (do_shift && (cnt != CNT_FULL)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow configuration: only changes on an accepted commit, so muxes never see partial loads.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      mem_out   <= '0;
      cfg_valid <= 1'b0;
      cmt_err   <= 1'b0;
    end else begin
      if (do_load) begin
        mem_out   <= shreg[L-1 -: TOTAL];
        cfg_valid <= 1'b1;
      end
      if (do_reject) begin
        cmt_err <= 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky record of a commit refused because the loaded frame had odd parity.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      par_err <= 1'b0;
    end else if (commit && (state == FULL) && !parity_ok) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign ccff_tail = shreg[L-1];
  assign mem_outb  = ~mem_out;

endmodule

// File: tb/tb_fabric_cfg_chain.sv
module tb_fabric_cfg_chain;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b1;
  logic       ccff_head = 1'b0;
  logic       shift_en  = 1'b0;
  logic       commit    = 1'b0;
  logic       ccff_tail;
  logic [7:0] mem_out;
  logic [7:0] mem_outb;
  logic       cfg_valid;
  logic       cmt_err;
  logic       par_err;

  int tests = 0;
  int fails = 0;

  fabric_cfg_chain #(.NUM_MUX(4), .SEL_BITS(2)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .commit    (commit),
    .ccff_tail (ccff_tail),
    .mem_out   (mem_out),
    .mem_outb  (mem_outb),
    .cfg_valid (cfg_valid),
    .cmt_err   (cmt_err),
    .par_err   (par_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic shift_bit(input logic b);
    ccff_head = b;
    shift_en  = 1'b1;
    @(posedge prog_clk); #1;
    shift_en  = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(posedge prog_clk); #1;
    commit = 1'b0;
  endtask

  task automatic test_reset();
    // Shift and commit requested on an edge while reset is held must be ignored.
    pReset = 1'b1; shift_en = 1'b1; commit = 1'b1; ccff_head = 1'b1;
    @(posedge prog_clk); #1;
    tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", dut.cnt); end
    tests++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL reset_tail got %b want 0", ccff_tail); end
    tests++; if (mem_out !== 8'h00) begin fails++; $display("FAIL reset_mem got %h want 00", mem_out); end
    tests++; if (mem_outb !== 8'hFF) begin fails++; $display("FAIL reset_memb got %h want ff", mem_outb); end
    tests++; if ({cfg_valid, cmt_err, par_err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {cfg_valid, cmt_err, par_err}); end
    shift_en = 1'b0; commit = 1'b0; ccff_head = 1'b0;
    pReset = 1'b0;
    @(posedge prog_clk); #1;
  endtask

`ifndef PARITY_CHECK_EN
  task automatic test_load();
    shift_byte(8'hB2);
    tests++; if (ccff_tail !== 1'b1) begin fails++; $display("FAIL load_tail got %b want 1", ccff_tail); end
    tests++; if (dut.cnt !== 4'd8) begin fails++; $display("FAIL load_cnt_full got %0d want 8", dut.cnt); end
    tests++; if (mem_out !== 8'h00) begin fails++; $display("FAIL load_mem_pre got %h want 00", mem_out); end
    do_commit();
    tests++; if (mem_out !== 8'hB2) begin fails++; $display("FAIL load_mem got %h want b2", mem_out); end
    tests++; if (mem_outb !== 8'h4D) begin fails++; $display("FAIL load_memb got %h want 4d", mem_outb); end
    tests++; if (cfg_valid !== 1'b1) begin fails++; $display("FAIL load_valid got %b want 1", cfg_valid); end
    tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL load_cnt got %0d want 0", dut.cnt); end
    tests++; if (cmt_err !== 1'b0) begin fails++; $display("FAIL load_cmt_err got %b want 0", cmt_err); end
  endtask

  task automatic test_shadow();
    logic [7:0] v;
    v = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      shift_bit(v[i]);
      tests++; if (mem_out !== 8'hB2) begin fails++; $display("FAIL shadow_hold bit %0d got %h want b2", i, mem_out); end
    end
    do_commit();
    tests++; if (mem_out !== 8'h5A) begin fails++; $display("FAIL shadow_mem got %h want 5a", mem_out); end
  endtask

  task automatic test_commit_priority();
    shift_byte(8'h96);
    tests++; if (ccff_tail !== 1'b1) begin fails++; $display("FAIL prio_tail_pre got %b want 1", ccff_tail); end
    commit = 1'b1; shift_en = 1'b1; ccff_head = 1'b0;
    @(posedge prog_clk); #1;
    commit = 1'b0; shift_en = 1'b0;
    tests++; if (mem_out !== 8'h96) begin fails++; $display("FAIL prio_mem got %h want 96", mem_out); end
    tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL prio_cnt got %0d want 0", dut.cnt); end
    tests++; if (ccff_tail !== 1'b1) begin fails++; $display("FAIL prio_tail got %b want 1", ccff_tail); end
  endtask

  task automatic test_saturate();
    logic [9:0] bits;
    bits = 10'b01_1010_0101;
    for (int i = 9; i >= 2; i--) shift_bit(bits[i]);
    tests++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL sat_tail8 got %b want 0", ccff_tail); end
    shift_bit(bits[1]);
    shift_bit(bits[0]);
    tests++; if (dut.cnt !== 4'd8) begin fails++; $display("FAIL sat_cnt got %0d want 8", dut.cnt); end
    tests++; if (ccff_tail !== 1'b1) begin fails++; $display("FAIL sat_tail10 got %b want 1", ccff_tail); end
    tests++; if (mem_out !== 8'h96) begin fails++; $display("FAIL sat_mem_hold got %h want 96", mem_out); end
    do_commit();
    tests++; if (mem_out !== 8'hA5) begin fails++; $display("FAIL sat_mem got %h want a5", mem_out); end
  endtask

  task automatic test_early_commit();
    pReset = 1'b1; #2; pReset = 1'b0;
    @(posedge prog_clk); #1;
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    do_commit();
    tests++; if (cmt_err !== 1'b1) begin fails++; $display("FAIL early_cmt_err got %b want 1", cmt_err); end
    tests++; if (mem_out !== 8'h00) begin fails++; $display("FAIL early_mem got %h want 00", mem_out); end
    tests++; if (cfg_valid !== 1'b0) begin fails++; $display("FAIL early_valid got %b want 0", cfg_valid); end
    tests++; if (dut.cnt !== 4'd5) begin fails++; $display("FAIL early_cnt got %0d want 5", dut.cnt); end
    tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL early_par_err got %b want 0", par_err); end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    pReset = 1'b1; #2;
    tests++; if ({mem_out, cfg_valid, cmt_err, par_err, ccff_tail} !== 12'h000) begin fails++; $display("FAIL midrst_outs got %h want 000", {mem_out, cfg_valid, cmt_err, par_err, ccff_tail}); end
    tests++; if (mem_outb !== 8'hFF) begin fails++; $display("FAIL midrst_memb got %h want ff", mem_outb); end
    tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL midrst_cnt got %0d want 0", dut.cnt); end
    pReset = 1'b0;
    @(posedge prog_clk); #1;
    shift_byte(8'h3C);
    do_commit();
    tests++; if (mem_out !== 8'h3C) begin fails++; $display("FAIL midrst_mem got %h want 3c", mem_out); end
    tests++; if ({cfg_valid, cmt_err} !== 2'b10) begin fails++; $display("FAIL midrst_flags got %b want 10", {cfg_valid, cmt_err}); end
  endtask
`else
  task automatic test_parity();
    shift_byte(8'hB2);
    shift_bit(1'b0);
    tests++; if (dut.cnt !== 4'd9) begin fails++; $display("FAIL par_cnt_full got %0d want 9", dut.cnt); end
    do_commit();
    tests++; if (mem_out !== 8'hB2) begin fails++; $display("FAIL par_good_mem got %h want b2", mem_out); end
    tests++; if ({cfg_valid, cmt_err, par_err} !== 3'b100) begin fails++; $display("FAIL par_good_flags got %b want 100", {cfg_valid, cmt_err, par_err}); end
    tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL par_good_cnt got %0d want 0", dut.cnt); end
    shift_byte(8'h5A);
    shift_bit(1'b1);
    do_commit();
    tests++; if (mem_out !== 8'hB2) begin fails++; $display("FAIL par_bad_mem got %h want b2", mem_out); end
    tests++; if ({cmt_err, par_err} !== 2'b11) begin fails++; $display("FAIL par_bad_flags got %b want 11", {cmt_err, par_err}); end
    tests++; if (dut.cnt !== 4'd9) begin fails++; $display("FAIL par_bad_cnt got %0d want 9", dut.cnt); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PARITY_CHECK_EN
    test_load();
    test_shadow();
    test_commit_priority();
    test_saturate();
    test_early_commit();
    test_reset_midload();
`else
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
